// File: rtl/mdio_mem_rdback.sv
// Burst read-back sequencer: issues auto-incrementing capture-memory reads and queues the
// returned words in a first-word-fall-through FIFO. Define MDIO_RDBK_PARITY_EN for per-entry parity.
module mdio_mem_rdback #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 9,
   parameter int SEL_W      = 7,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT_W  = 8
) (
   input  logic                        clk_200m,
   input  logic                        rstn_200m,
   input  logic                        cfg_start,
   input  logic                        cfg_abort,
   input  logic [ADDR_W-1:0]           cfg_base_addr,
   input  logic [7:0]                  cfg_burst_len,
   input  logic [SEL_W-1:0]            cfg_data_sel,
   input  logic [TIMEOUT_W-1:0]        cfg_timeout,
   output logic                        rd_req,
   output logic [ADDR_W-1:0]           rd_addr,
   output logic [SEL_W-1:0]            rd_sel,
   input  logic                        rd_ack,
   input  logic [DATA_W-1:0]           rd_data,
   input  logic                        fifo_pop,
   output logic [DATA_W-1:0]           fifo_data,
   output logic                        fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        busy,
   output logic                        done,
   output logic                        timeout_err,
   output logic                        par_err,
   output logic [8:0]                  word_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
`ifdef MDIO_RDBK_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPACE,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_t;

   state_t               state;
   logic [8:0]           len_q;
   logic [TIMEOUT_W-1:0] tmo_q;
   logic [TIMEOUT_W-1:0] tmo_cnt;

   logic [MEM_W-1:0]     fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [MEM_W-1:0]     head;
   logic [MEM_W-1:0]     push_word;

   logic                 start_ok;
   logic                 push;
   logic                 pop;
   logic [TIMEOUT_W-1:0] tmo_next;
   logic [8:0]           word_next;

   assign start_ok  = (state == S_IDLE) && cfg_start;
   assign push      = (state == S_WAIT) && rd_ack;
   assign pop       = fifo_pop && (fifo_level != '0);
   assign tmo_next  = tmo_cnt + 1'b1;
   assign word_next = word_cnt + 9'd1;

   // ---------------------------------------------------------------- sequencer
   // NOTE: every sequential update uses <= so all branches act on pre-edge values.
   always_ff @(posedge clk_200m or negedge rstn_200m) begin
      if (!rstn_200m) begin
         state       <= S_IDLE;
         rd_req      <= 1'b0;
         rd_addr     <= '0;
         rd_sel      <= '0;
         len_q       <= '0;
         tmo_q       <= '0;
         tmo_cnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         word_cnt    <= '0;
      end else begin
         rd_req <= 1'b0;
         done   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               // Start beats a simultaneous abort; a held abort ends the burst one cycle later.
               if (cfg_start) begin
                  rd_addr     <= cfg_base_addr;
                  rd_sel      <= cfg_data_sel;
                  len_q       <= {(cfg_burst_len == 8'd0), cfg_burst_len};
                  tmo_q       <= cfg_timeout;
                  word_cnt    <= '0;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  state       <= S_SPACE;
               end
            end
            S_SPACE: begin
               if (cfg_abort) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (fifo_level < LVL_W'(FIFO_DEPTH)) begin
                  rd_req <= 1'b1;
                  state  <= S_REQ;
               end
            end
            S_REQ: begin
               tmo_cnt <= '0;
               if (cfg_abort) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (rd_ack) begin
                  word_cnt <= word_next;
                  rd_addr  <= rd_addr + 1'b1;
                  if (cfg_abort || (word_next == len_q)) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state <= S_SPACE;
                  end
               end else if (cfg_abort) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_next;
                  if ((tmo_q != '0) && (tmo_next == tmo_q)) begin
                     timeout_err <= 1'b1;
                     done        <= 1'b1;
                     state       <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- result FIFO
   always_ff @(posedge clk_200m or negedge rstn_200m) begin
      if (!rstn_200m) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else if (start_ok) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_level <= fifo_level + 1'b1;
         else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      end
   end

   // NOTE: the storage array has no reset; fifo_data is masked while empty so stale entries never show.
   always_ff @(posedge clk_200m) begin
      if (push) fifo_mem[wr_ptr] <= push_word;
   end

   assign head       = fifo_mem[rd_ptr];
   assign fifo_empty = (fifo_level == '0);
   assign fifo_data  = fifo_empty ? '0 : head[DATA_W-1:0];

`ifdef MDIO_RDBK_PARITY_EN
   // Even parity: the stored bit makes data plus parity an even number of ones.
   assign push_word = {^rd_data, rd_data};

   always_ff @(posedge clk_200m or negedge rstn_200m) begin
      if (!rstn_200m) begin
         par_err <= 1'b0;
      end else if (start_ok) begin
         par_err <= 1'b0;
      end else if (pop && ((^head[DATA_W-1:0]) != head[DATA_W])) begin
         par_err <= 1'b1;
      end
   end
`else
   assign push_word = rd_data;
   assign par_err   = 1'b0;
`endif

endmodule
